// File: rtl/prog_sequence_counter.sv
// rtl/prog_sequence_counter.sv - programmable-table sequence counter with wrap/one-shot modes
module prog_sequence_counter #(
    parameter int                          WIDTH    = 3,
    parameter int                          DEPTH    = 8,
    parameter logic [WIDTH*DEPTH-1:0]      INIT_SEQ = {3'd0, 3'd0, 3'd2, 3'd3, 3'd6, 3'd7, 3'd5, 3'd0},
    parameter int                          INIT_LEN = 6,
    localparam int                         AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             one_shot,
    input  logic             restart,
    input  logic             len_wr,
    input  logic [AW:0]      len_in,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] q,
    output logic [AW-1:0]    idx,
    output logic             wrap,
    output logic             done
);

    localparam int            LW      = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH*DEPTH-1:0] table_q, table_d;
    logic [LW-1:0]          len_q, len_d, len_new, len_m1;
    logic [AW-1:0]          idx_q, idx_d;
    logic                   wrap_q, wrap_d;
    logic                   done_q, done_d;
    logic                   at_end;

    function automatic logic [AW-1:0] start_idx(input logic [LW-1:0] l, input logic d);
        logic [LW-1:0] m;
        m = l - LW'(1);
        return d ? m[AW-1:0] : '0;
    endfunction

    always_comb begin
        len_new = len_in;
        if (len_in == '0) begin
            len_new = LW'(1);
        end else if (len_in > DEPTH_L) begin
            len_new = DEPTH_L;
        end
    end

    // An index at or beyond len (only possible transiently) always counts as an end.
    assign len_m1 = len_q - LW'(1);
    assign at_end = dir ? ((idx_q == '0) || ({1'b0, idx_q} >= len_q))
                        : ({1'b0, idx_q} >= len_m1);

    always_comb begin
        table_d = table_q;
        if (wr_en) begin
            table_d[int'(wr_addr)*WIDTH +: WIDTH] = wr_data;
        end
    end

    always_comb begin
        idx_d  = idx_q;
        len_d  = len_q;
        wrap_d = 1'b0;
        done_d = done_q;
        if (restart) begin
            idx_d  = start_idx(len_q, dir);
            done_d = 1'b0;
        end else if (len_wr) begin
            len_d  = len_new;
            idx_d  = start_idx(len_new, dir);
            done_d = 1'b0;
        end else if (en && !done_q) begin
            if (!at_end) begin
                idx_d = dir ? (idx_q - AW'(1)) : (idx_q + AW'(1));
            end else if (one_shot) begin
                done_d = 1'b1;
            end else begin
                idx_d  = start_idx(len_q, dir);
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            table_q <= INIT_SEQ;
            len_q   <= LW'(INIT_LEN);
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            table_q <= table_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign q    = table_q[int'(idx_q)*WIDTH +: WIDTH];
    assign idx  = idx_q;
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_prog_sequence_counter.sv
// tb/tb_prog_sequence_counter.sv - directed vector table plus randomized model check
module tb_prog_sequence_counter;

    localparam int W  = 3;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en, dir, one_shot, restart, len_wr, wr_en;
    logic [AW:0]   len_in;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  q;
    logic [AW-1:0] idx;
    logic          wrap, done;

    int n_chk  = 0;
    int n_fail = 0;

    prog_sequence_counter dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .one_shot (one_shot),
        .restart  (restart),
        .len_wr   (len_wr),
        .len_in   (len_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .q        (q),
        .idx      (idx),
        .wrap     (wrap),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en, dir, os, rs, lw;
        logic [3:0] li;
        int         eq, ei, ew, ed;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic e, input logic d, input logic o, input logic r,
                                input logic l, input logic [3:0] li,
                                input int eq, input int ei, input int ew, input int ed);
        vec_t v;
        v = '{en: e, dir: d, os: o, rs: r, lw: l, li: li, eq: eq, ei: ei, ew: ew, ed: ed};
        vq.push_back(v);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int eq, input int ei, input int ew, input int ed);
        chk({tag, ".q"},    32'(q),    eq);
        chk({tag, ".idx"},  32'(idx),  ei);
        chk({tag, ".wrap"}, 32'(wrap), ew);
        chk({tag, ".done"}, 32'(done), ed);
    endtask

    task automatic idle_inputs;
        en = 0; dir = 0; one_shot = 0; restart = 0; len_wr = 0;
        len_in = '0; wr_en = 0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic do_write(input int a, input int d);
        idle_inputs();
        wr_en = 1; wr_addr = AW'(a); wr_data = W'(d);
        tick();
        wr_en = 0;
    endtask

    // Reference model state for the random phase
    int m_tbl[D];
    int m_len, m_idx, m_wrap, m_done;

    task automatic model_reset;
        int init[D] = '{0, 5, 7, 6, 3, 2, 0, 0};
        for (int i = 0; i < D; i++) m_tbl[i] = init[i];
        m_len = 6; m_idx = 0; m_wrap = 0; m_done = 0;
    endtask

    task automatic model_step;
        bit hit_end;
        if (wr_en) m_tbl[wr_addr] = int'(wr_data);
        if (restart) begin
            m_idx = dir ? m_len - 1 : 0; m_done = 0; m_wrap = 0;
        end else if (len_wr) begin
            m_len = (len_in == 0) ? 1 : ((int'(len_in) > D) ? D : int'(len_in));
            m_idx = dir ? m_len - 1 : 0; m_done = 0; m_wrap = 0;
        end else if (en && m_done == 0) begin
            hit_end = dir ? (m_idx == 0 || m_idx >= m_len) : (m_idx >= m_len - 1);
            if (!hit_end) begin
                m_idx = dir ? m_idx - 1 : m_idx + 1; m_wrap = 0;
            end else if (one_shot) begin
                m_done = 1; m_wrap = 0;
            end else begin
                m_idx = dir ? m_len - 1 : 0; m_wrap = 1;
            end
        end else begin
            m_wrap = 0;
        end
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        #12;
        chk_all("reset", 0, 0, 0, 0);
        rst = 1;
        tick();
        chk_all("post_reset", 0, 0, 0, 0);

        // Forward default pattern
        add(1,0,0,0,0,0, 5,1,0,0); add(1,0,0,0,0,0, 7,2,0,0); add(1,0,0,0,0,0, 6,3,0,0);
        add(1,0,0,0,0,0, 3,4,0,0); add(1,0,0,0,0,0, 2,5,0,0); add(1,0,0,0,0,0, 0,0,1,0);
        add(1,0,0,0,0,0, 5,1,0,0);
        // Backward
        add(0,1,0,1,0,0, 2,5,0,0);
        add(1,1,0,0,0,0, 3,4,0,0); add(1,1,0,0,0,0, 6,3,0,0); add(1,1,0,0,0,0, 7,2,0,0);
        add(1,1,0,0,0,0, 5,1,0,0); add(1,1,0,0,0,0, 0,0,0,0); add(1,1,0,0,0,0, 2,5,1,0);
        add(1,1,0,0,0,0, 3,4,0,0);
        // One-shot
        add(0,0,1,1,0,0, 0,0,0,0);
        add(1,0,1,0,0,0, 5,1,0,0); add(1,0,1,0,0,0, 7,2,0,0); add(1,0,1,0,0,0, 6,3,0,0);
        add(1,0,1,0,0,0, 3,4,0,0); add(1,0,1,0,0,0, 2,5,0,0); add(1,0,1,0,0,0, 2,5,0,1);
        add(1,0,1,0,0,0, 2,5,0,1); add(1,0,1,0,0,0, 2,5,0,1);
        add(1,1,0,0,0,0, 2,5,0,1);
        add(0,0,0,1,0,0, 0,0,0,0);
        // Clamp 15 -> 8, then full 8-entry run
        add(0,0,0,0,1,15, 0,0,0,0);
        add(1,0,0,0,0,0, 5,1,0,0); add(1,0,0,0,0,0, 7,2,0,0); add(1,0,0,0,0,0, 6,3,0,0);
        add(1,0,0,0,0,0, 3,4,0,0); add(1,0,0,0,0,0, 2,5,0,0); add(1,0,0,0,0,0, 0,6,0,0);
        add(1,0,0,0,0,0, 0,7,0,0); add(1,0,0,0,0,0, 0,0,1,0);
        // restart + len_wr + en together: start index only, no step
        add(1,1,0,1,1,15, 0,7,0,0);
        // len 0 -> 1 backward: every step wraps
        add(0,1,0,0,1,0, 0,0,0,0);
        add(1,1,0,0,0,0, 0,0,1,0); add(1,1,0,0,0,0, 0,0,1,0);
        add(0,0,0,0,1,6, 0,0,0,0);

        foreach (vq[i]) begin
            en = vq[i].en; dir = vq[i].dir; one_shot = vq[i].os;
            restart = vq[i].rs; len_wr = vq[i].lw; len_in = vq[i].li;
            tick();
            chk_all($sformatf("vec%0d", i), vq[i].eq, vq[i].ei, vq[i].ew, vq[i].ed);
        end

        // Reprogram table; writing the current entry shows on q the next cycle
        do_write(0, 1);
        chk_all("wr_cur", 1, 0, 0, 0);
        do_write(1, 2); do_write(2, 4); do_write(3, 6);
        idle_inputs(); len_wr = 1; len_in = 4; tick();
        chk_all("rp_len", 1, 0, 0, 0);
        idle_inputs(); en = 1;
        tick(); chk_all("rp1", 2, 1, 0, 0);
        tick(); chk_all("rp2", 4, 2, 0, 0);
        tick(); chk_all("rp3", 6, 3, 0, 0);
        tick(); chk_all("rp4", 1, 0, 1, 0);
        en = 0; len_wr = 1; len_in = 0; tick();
        chk_all("len1", 1, 0, 0, 0);
        len_wr = 0; en = 1;
        for (int k = 0; k < 3; k++) begin
            tick(); chk_all($sformatf("len1_run%0d", k), 1, 0, 1, 0);
        end

        // Async reset mid-run at q=6 restores the table
        idle_inputs(); len_wr = 1; len_in = 6; tick();
        len_wr = 0; en = 1;
        tick(); tick(); tick();
        chk_all("pre_areset", 6, 3, 0, 0);
        #2 rst = 0;
        #1 chk_all("areset", 0, 0, 0, 0);
        #1 rst = 1;
        tick(); chk_all("restored1", 5, 1, 0, 0);
        tick(); chk_all("restored2", 7, 2, 0, 0);

        // Randomized phase against the reference model
        idle_inputs();
        rst = 0; #1; rst = 1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            en       = ($urandom_range(0, 3) != 0);
            dir      = ($urandom_range(0, 7) == 0) ? ~dir : dir;
            one_shot = ($urandom_range(0, 3) == 0);
            restart  = ($urandom_range(0, 15) == 0);
            len_wr   = ($urandom_range(0, 15) == 0);
            len_in   = (AW+1)'($urandom_range(0, 15));
            wr_en    = ($urandom_range(0, 3) == 0);
            wr_addr  = AW'($urandom_range(0, D-1));
            wr_data  = W'($urandom_range(0, (1 << W) - 1));
            model_step();
            tick();
            chk_all($sformatf("rnd%0d", c), m_tbl[m_idx], m_idx, m_wrap, m_done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
